// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, one bit per clock, LSB first.
// Optional subtract mode (sub_in port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] resSh_q, resSh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             bitSum, bitCarry, load;
  logic [WIDTH-1:0] bLoad;
  logic             cyLoad;

  // Subtraction is a + ~b + 1, so only the loaded B operand and initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign bLoad  = sub_in ? ~b_in : b_in;
  assign cyLoad = sub_in ? 1'b1 : c_in;
`else
  assign bLoad  = b_in;
  assign cyLoad = c_in;
`endif

  assign bitSum   = aSh_q[0] ^ bSh_q[0] ^ cy_q;
  assign bitCarry = (aSh_q[0] & bSh_q[0]) | (cy_q & (aSh_q[0] ^ bSh_q[0]));

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    resSh_d = resSh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        resSh_d = {bitSum, resSh_q[WIDTH-1:1]};
        cy_d    = bitCarry;
        cnt_d   = cnt_q + CW'(1);
        // On the MSB cycle cy_q is the carry into bit WIDTH-1, giving overflow directly.
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {bitSum, resSh_q[WIDTH-1:1]};
          carry_d = bitCarry;
          ovf_d   = cy_q ^ bitCarry;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      aSh_d   = a_in;
      bSh_d   = bLoad;
      cy_d    = cyLoad;
      cnt_d   = '0;
      resSh_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      resSh_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      resSh_q <= resSh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Subtract-mode vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int BOUND = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_in = 1'b0;
`endif
  logic             busy, done, carry, overflow;
  logic [WIDTH-1:0] sum;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in   (sub_in),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles and watching that sum holds meanwhile.
  task automatic waitDone(input string tag, input int expBusy);
    logic [WIDTH-1:0] sum0;
    int               busyCycles;
    int               guard;
    bit               sumStable;
    sum0       = sum;
    busyCycles = 0;
    guard      = 0;
    sumStable  = 1'b1;
    while (done !== 1'b1 && guard < BOUND) begin
      if (busy === 1'b1) busyCycles++;
      if (sum !== sum0) sumStable = 1'b0;
      tick();
      guard++;
    end
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    checkOutput({tag, " busyCycles"}, 64'(busyCycles), 64'(expBusy));
    checkOutput({tag, " sumHeld"}, 64'(sumStable), 64'd1);
    checkOutput({tag, " busyInDone"}, 64'(busy), 64'd0);
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] expSum,
                             input logic expCarry, input logic expOvf);
    checkOutput({tag, " sum"}, 64'(sum), 64'(expSum));
    checkOutput({tag, " carry"}, 64'(carry), 64'(expCarry));
    checkOutput({tag, " overflow"}, 64'(overflow), 64'(expOvf));
  endtask

  task automatic runAdd(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] expSum, input logic expCarry,
                        input logic expOvf);
    applyStimulus(a, b, c);
    waitDone(tag, WIDTH);
    checkResult(tag, expSum, expCarry, expOvf);
    tick();
    checkOutput({tag, " donePulse"}, 64'(done), 64'd0);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic runSub(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] expSum, input logic expCarry,
                        input logic expOvf);
    sub_in = 1'b1;
    applyStimulus(a, b, c);
    sub_in = 1'b0;
    waitDone(tag, WIDTH);
    checkResult(tag, expSum, expCarry, expOvf);
    tick();
  endtask
`endif

  initial begin
    int  t0, d1, d2;
    bit  sawDone;

    $display("[TB] serial_adder directed test, WIDTH=%0d", WIDTH);

    // Reset state
    tick();
    tick();
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst done", 64'(done), 64'd0);
    checkResult("rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // First start accepted on the first edge after reset release
    runAdd("add0F01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    runAdd("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runAdd("add7F00c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    runAdd("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Start pulsed mid-RUN must be ignored
    applyStimulus(8'h12, 8'h34, 1'b0);
    tick();
    tick();
    tick();
    a_in  = 8'hAA;
    b_in  = 8'h55;
    c_in  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("midrun sumHeldPrev", 64'(sum), 64'h00);
    waitDone("midrun", WIDTH - 4);
    checkResult("midrun", 8'h46, 1'b0, 1'b0);
    tick();
    checkOutput("midrun idle", 64'(busy), 64'd0);

    // Back-to-back with start held high across DONE
    a_in  = 8'h01;
    b_in  = 8'h01;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    t0 = cyc;
    waitDone("b2b first", WIDTH);
    d1 = cyc;
    checkOutput("b2b latency", 64'(d1 - t0), 64'(WIDTH));
    checkResult("b2b first", 8'h02, 1'b0, 1'b0);
    a_in = 8'h02;
    b_in = 8'h02;
    tick();
    start = 1'b0;
    checkOutput("b2b rerun busy", 64'(busy), 64'd1);
    waitDone("b2b second", WIDTH);
    d2 = cyc;
    checkOutput("b2b spacing", 64'(d2 - d1), 64'(WIDTH + 1));
    checkResult("b2b second", 8'h04, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in RUN cycle 4 aborts the operation
    applyStimulus(8'h55, 8'h22, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkResult("abort", 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
      tick();
    end
    checkOutput("abort noDone", 64'(sawDone), 64'd0);
    runAdd("add0304", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    runSub("sub0507", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    runSub("sub8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    runSub("sub0303c", 8'h03, 8'h03, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk edge.
REQ-005 Port: a_in  input  WIDTH  operand A, two's complement or unsigned; sampled with start.
REQ-006 Port: b_in  input  WIDTH  operand B; sampled with start.
REQ-007 Port: c_in  input  1  carry-in; sampled with start.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse when a result is committed.
REQ-010 Port: sum  output  WIDTH  last committed result.
REQ-011 Port: carry  output  1  carry-out of last committed result.
REQ-012 Port: overflow  output  1  signed overflow of last committed result.

Function
REQ-013 The block SHALL be a bit-serial adder: one full-adder cell plus a carry flip-flop, processing one bit per clock, LSB first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL load a_in, b_in into shift registers, load c_in into the carry flip-flop, clear the bit counter and enter RUN.
REQ-016 In RUN, each cycle SHALL add the current LSBs and the carry, shift the sum bit into an internal shift register from the MSB end, update the carry and increment the counter.
REQ-017 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE, and the internal result, final carry and overflow SHALL be copied to sum, carry and overflow.
REQ-018 Overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE, for one cycle.
REQ-020 Latency: start sampled at edge T -> busy high from T+1 to T+WIDTH -> done high in cycle after edge T+WIDTH.
REQ-021 sum, carry and overflow SHALL hold their previous values throughout RUN and change only on entry to DONE.
REQ-022 start while in RUN SHALL be ignored; operands in flight SHALL be unaffected.
REQ-023 In DONE with start=1, the block SHALL load new operands and enter RUN directly (back-to-back, one result per WIDTH+1 cycles).
REQ-024 In DONE with start=0, the FSM SHALL return to IDLE.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; carry SHALL be bit WIDTH of the unsigned sum a_in+b_in+c_in.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE and clear busy, done, sum, carry, overflow, the counter and all shift registers to 0.
REQ-027 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow the deassertion of rst.
REQ-028 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN SHALL, when defined, add port sub_in  input  1, sampled with start.
REQ-030 With SERIAL_ADDER_SUB_EN and sub_in=1, the block SHALL compute a_in - b_in by loading ~b_in and forcing the initial carry to 1; c_in SHALL be ignored; carry=1 SHALL mean no borrow.
REQ-031 With SERIAL_ADDER_SUB_EN and sub_in=0, or without the macro, the behaviour SHALL be addition per REQ-015..REQ-025, and without the macro no sub_in port SHALL exist.

Verification (WIDTH=8)
REQ-032 a_in=0x0F, b_in=0x01, c_in=0, start at edge T -> busy for 8 cycles, done in cycle after T+8, sum=0x10, carry=0, overflow=0.
REQ-033 a_in=0xFF, b_in=0x01, c_in=0 -> sum=0x00, carry=1, overflow=0; a_in=0x7F, b_in=0x00, c_in=1 -> sum=0x80, carry=0, overflow=1.
REQ-034 start pulsed again mid-RUN with different operands -> ignored; the result matches the first operands; sum unchanged until done.
REQ-035 start held high across DONE with 0x01+0x01 then 0x02+0x02 -> done pulses 9 cycles apart; sum=0x02 then 0x04.
REQ-036 rst asserted at RUN cycle 4 -> all outputs 0 immediately; no done pulse; a new 0x03+0x04 after release gives sum=0x07.
REQ-037 With SERIAL_ADDER_SUB_EN, a_in=0x05, b_in=0x07, sub_in=1 -> sum=0xFE, carry=0, overflow=0; a_in=0x80, b_in=0x01, sub_in=1 -> sum=0x7F, carry=1, overflow=1.
